reorder_buffer_mc: RTL and testbench

Parametrised, multi-commit successor to the single-commit reorder buffer. It is a circular in-order retirement queue and does no fetching or issuing:
- receives allocations from the issue stage;
- captures results from the per-entry CDB_data buses;
- retires up to COMMIT_WIDTH register writes per cycle;
- drains stores through a mem_hit handshake instead of fixed stalls;
- resolves taken branches precisely at commit with a flush and PC redirect.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/rb_commit_select.sv | 55 +++++
 rtl/reorder_buffer_mc.sv | 149 ++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths and reorder-buffer entry kinds.
package cpu_pkg;
    localparam int WORD_SIZE = 32;
    localparam int REG_INDEX = 5;
    localparam int FU_NUM    = 8;
    localparam int FU_INDEX  = $clog2(FU_NUM);

    typedef enum logic [1:0] {
        KIND_REG    = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10
    } entry_kind_e;
endpackage

// File: rtl/rb_commit_select.sv
// rb_commit_select: picks which head-relative entries retire this cycle and
// builds the functional-unit squash mask for a taken-branch flush.
module rb_commit_select #(
    parameter int RB_SIZE      = 8,
    parameter int RB_INDEX     = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int FU_NUM       = 8,
    parameter int FU_INDEX     = 3
) (
    input  logic [RB_INDEX-1:0]               head,
    input  logic [RB_SIZE-1:0]                valid,
    input  logic [RB_SIZE-1:0]                done,
    input  logic [RB_SIZE-1:0]                taken,
    input  logic [RB_SIZE-1:0][1:0]           kind,
    input  logic [RB_SIZE-1:0][FU_INDEX-1:0]  fu,
    input  logic                              mem_hit,
    output logic [COMMIT_WIDTH-1:0]           slot_reg,
    output logic                              store_req,
    output logic                              flush_now,
    output logic [RB_INDEX:0]                 retire_num,
    output logic [FU_NUM-1:0]                 squash
);
    import cpu_pkg::*;

    logic                go;
    logic                ok;
    logic                rt;
    logic [RB_INDEX-1:0] idx;

    always_comb begin
        slot_reg   = '0;
        store_req  = 1'b0;
        flush_now  = 1'b0;
        retire_num = '0;
        squash     = '0;
        go         = 1'b1;
        ok         = 1'b0;
        rt         = 1'b0;
        idx        = head;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx = head + RB_INDEX'(k);
            ok  = go && valid[idx] && done[idx];
            if (k == 0 && kind[idx] == KIND_STORE) store_req = ok;
            if (k == 0 && kind[idx] == KIND_BRANCH) flush_now = ok && taken[idx];
            slot_reg[k] = ok && kind[idx] == KIND_REG;
            // stores and branches may only retire from slot 0 and always close the group
            rt = slot_reg[k] || (k == 0 && ok && (kind[idx] == KIND_BRANCH ||
                                                 (kind[idx] == KIND_STORE && mem_hit)));
            retire_num = retire_num + (RB_INDEX+1)'(rt);
            go = slot_reg[k];
        end
        for (int i = 0; i < RB_SIZE; i++)
            if (valid[i] && RB_INDEX'(i) != head) squash[fu[i]] = 1'b1;
    end
endmodule

// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc: circular in-order retirement queue with multi-slot register
// commit, handshaked store drain and precise taken-branch flush.
module reorder_buffer_mc #(
    parameter int WORD_SIZE    = cpu_pkg::WORD_SIZE,
    parameter int REG_INDEX    = cpu_pkg::REG_INDEX,
    parameter int RB_SIZE      = 8,
    parameter int RB_INDEX     = $clog2(RB_SIZE),
    parameter int FU_NUM       = cpu_pkg::FU_NUM,
    parameter int FU_INDEX     = $clog2(FU_NUM),
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alloc_valid,
    input  logic [1:0]                       alloc_kind,
    input  logic [REG_INDEX-1:0]             alloc_rdest,
    input  logic [FU_INDEX-1:0]              alloc_fu,
    output logic                             alloc_ready,
    output logic [RB_INDEX-1:0]              alloc_index,
    input  logic [RB_SIZE-1:0]               CDB_data_valid,
    input  logic [RB_SIZE*WORD_SIZE-1:0]     CDB_data_data,
    input  logic [RB_SIZE*WORD_SIZE-1:0]     CDB_data_addr,
    output logic [COMMIT_WIDTH-1:0]          we_reg,
    output logic [COMMIT_WIDTH*REG_INDEX-1:0] ws_reg,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0] wd_reg,
    output logic [COMMIT_WIDTH-1:0]          we_status_wb,
    output logic [COMMIT_WIDTH*RB_INDEX-1:0] RB_index_status_wb,
    output logic                             we_mem,
    output logic [WORD_SIZE-1:0]             ws_mem,
    output logic [WORD_SIZE-1:0]             wd_mem,
    input  logic                             mem_hit,
    output logic                             redirect_valid,
    output logic [WORD_SIZE-1:0]             redirect_pc,
    output logic [FU_NUM-1:0]                reset_out,
    output logic [RB_INDEX:0]                count
);
    import cpu_pkg::*;

    logic [RB_INDEX-1:0]              head;
    logic [RB_INDEX-1:0]              tail;
    logic [RB_SIZE-1:0]               valid;
    logic [RB_SIZE-1:0]               done;
    logic [RB_SIZE-1:0]               taken;
    logic [RB_SIZE-1:0][1:0]          kind;
    logic [RB_SIZE-1:0][FU_INDEX-1:0] fu;
    logic [REG_INDEX-1:0]             rdest [RB_SIZE];
    logic [WORD_SIZE-1:0]             data  [RB_SIZE];
    logic [WORD_SIZE-1:0]             addr  [RB_SIZE];

    logic [COMMIT_WIDTH-1:0] slot_reg;
    logic                    store_req;
    logic                    flush_now;
    logic [RB_INDEX:0]       retire_num;
    logic [FU_NUM-1:0]       squash;
    logic [FU_NUM-1:0]       squash_q;
    logic                    accept;
    logic [RB_INDEX-1:0]     sidx;

    rb_commit_select #(
        .RB_SIZE(RB_SIZE), .RB_INDEX(RB_INDEX), .COMMIT_WIDTH(COMMIT_WIDTH),
        .FU_NUM(FU_NUM), .FU_INDEX(FU_INDEX)
    ) u_sel (
        .head(head), .valid(valid), .done(done), .taken(taken), .kind(kind), .fu(fu),
        .mem_hit(mem_hit), .slot_reg(slot_reg), .store_req(store_req),
        .flush_now(flush_now), .retire_num(retire_num), .squash(squash)
    );

    assign alloc_ready = count < (RB_INDEX+1)'(RB_SIZE) && !flush_now;
    assign accept      = alloc_valid && alloc_ready;
    assign alloc_index = tail;
    assign we_reg       = slot_reg;
    assign we_status_wb = slot_reg;
    assign we_mem       = store_req;
    assign ws_mem       = addr[head];
    assign wd_mem       = data[head];
    assign reset_out    = !reset ? '1 : squash_q;

    always_comb begin
        taken              = '0;
        ws_reg             = '0;
        wd_reg             = '0;
        RB_index_status_wb = '0;
        sidx               = head;
        for (int i = 0; i < RB_SIZE; i++) taken[i] = |data[i];
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            sidx = head + RB_INDEX'(k);
            ws_reg[k*REG_INDEX +: REG_INDEX]           = rdest[sidx];
            wd_reg[k*WORD_SIZE +: WORD_SIZE]           = data[sidx];
            RB_index_status_wb[k*RB_INDEX +: RB_INDEX] = sidx;
        end
    end

    // payload needs no reset: valid/done gate every use of it
    always_ff @(posedge clk) begin
        for (int i = 0; i < RB_SIZE; i++)
            if (valid[i] && !done[i] && CDB_data_valid[i]) begin
                data[i] <= CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
                addr[i] <= CDB_data_addr[i*WORD_SIZE +: WORD_SIZE];
            end
        if (accept) begin
            kind[tail]  <= alloc_kind;
            rdest[tail] <= alloc_rdest;
            fu[tail]    <= alloc_fu;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else if (flush_now) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            for (int i = 0; i < RB_SIZE; i++)
                if (valid[i] && !done[i] && CDB_data_valid[i]) done[i] <= 1'b1;
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (k < int'(retire_num)) begin
                    valid[head + RB_INDEX'(k)] <= 1'b0;
                    done[head + RB_INDEX'(k)]  <= 1'b0;
                end
            if (accept) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
            end
            head  <= head + retire_num[RB_INDEX-1:0];
            tail  <= tail + RB_INDEX'(accept);
            count <= count + (RB_INDEX+1)'(accept) - retire_num;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            squash_q       <= '0;
        end else begin
            redirect_valid <= flush_now;
            squash_q       <= flush_now ? squash : '0;
            if (flush_now) redirect_pc <= addr[head];
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc: directed scenario tests for reorder_buffer_mc.
module tb_reorder_buffer_mc;
    logic         clk;
    logic         reset;
    logic         alloc_valid;
    logic [1:0]   alloc_kind;
    logic [4:0]   alloc_rdest;
    logic [2:0]   alloc_fu;
    logic         alloc_ready;
    logic [2:0]   alloc_index;
    logic [7:0]   cdb_valid;
    logic [255:0] cdb_data;
    logic [255:0] cdb_addr;
    logic [1:0]   we_reg;
    logic [9:0]   ws_reg;
    logic [63:0]  wd_reg;
    logic [1:0]   we_status_wb;
    logic [5:0]   rb_index_status_wb;
    logic         we_mem;
    logic [31:0]  ws_mem;
    logic [31:0]  wd_mem;
    logic         mem_hit;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [7:0]   reset_out;
    logic [3:0]   count;
    int checks = 0;
    int errors = 0;

    reorder_buffer_mc dut (
        .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_kind(alloc_kind),
        .alloc_rdest(alloc_rdest), .alloc_fu(alloc_fu), .alloc_ready(alloc_ready),
        .alloc_index(alloc_index), .CDB_data_valid(cdb_valid), .CDB_data_data(cdb_data),
        .CDB_data_addr(cdb_addr), .we_reg(we_reg), .ws_reg(ws_reg), .wd_reg(wd_reg),
        .we_status_wb(we_status_wb), .RB_index_status_wb(rb_index_status_wb),
        .we_mem(we_mem), .ws_mem(ws_mem), .wd_mem(wd_mem), .mem_hit(mem_hit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .reset_out(reset_out), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] rd, input logic [2:0] f);
        alloc_valid = 1'b1;
        alloc_kind  = k;
        alloc_rdest = rd;
        alloc_fu    = f;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb(input int i, input logic [31:0] d, input logic [31:0] a);
        cdb_valid[i]         = 1'b1;
        cdb_data[i*32 +: 32] = d;
        cdb_addr[i*32 +: 32] = a;
    endtask

    task automatic cdb_go();
        tick();
        cdb_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
        checks++; if (we_reg !== 2'b00 || we_mem !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_enables got we_reg=%b we_mem=%b redir=%b expected 0", we_reg, we_mem, redirect_valid); end
        checks++; if (reset_out !== 8'hFF) begin errors++; $display("FAIL reset_out_low got %h expected ff", reset_out); end
        checks++; if (alloc_ready !== 1'b1 || alloc_index !== 3'd0) begin errors++; $display("FAIL reset_alloc got ready=%b idx=%0d expected 1/0", alloc_ready, alloc_index); end
        reset = 1'b1;
        tick();
        checks++; if (reset_out !== 8'h00) begin errors++; $display("FAIL reset_out_release got %h expected 00", reset_out); end
    endtask

    task automatic test_out_of_order();
        alloc(2'b00, 5'd1, 3'd0);
        alloc(2'b00, 5'd2, 3'd0);
        alloc(2'b00, 5'd3, 3'd0);
        cdb(2, 32'd10, 32'd0);
        cdb_go();
        checks++; if (we_reg !== 2'b00 || count !== 4'd3) begin errors++; $display("FAIL ooo_wait got we_reg=%b count=%0d expected 00/3", we_reg, count); end
        cdb(0, 32'd20, 32'd0);
        cdb(1, 32'd30, 32'd0);
        cdb_go();
        checks++; if (we_reg !== 2'b11 || we_status_wb !== 2'b11) begin errors++; $display("FAIL ooo_pair_we got %b/%b expected 11/11", we_reg, we_status_wb); end
        checks++; if (ws_reg !== {5'd2, 5'd1} || wd_reg !== {32'd30, 32'd20}) begin errors++; $display("FAIL ooo_pair_data got ws=%h wd=%h expected 041/%h", ws_reg, wd_reg, {32'd30, 32'd20}); end
        checks++; if (rb_index_status_wb !== {3'd1, 3'd0}) begin errors++; $display("FAIL ooo_pair_idx got %b expected 001000", rb_index_status_wb); end
        tick();
        checks++; if (we_reg !== 2'b01 || ws_reg[4:0] !== 5'd3 || wd_reg[31:0] !== 32'd10 || rb_index_status_wb[2:0] !== 3'd2) begin errors++; $display("FAIL ooo_third got we=%b ws=%0d wd=%0d idx=%0d expected 01/3/10/2", we_reg, ws_reg[4:0], wd_reg[31:0], rb_index_status_wb[2:0]); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL ooo_count got %0d expected 1", count); end
        tick();
        checks++; if (count !== 4'd0 || we_reg !== 2'b00) begin errors++; $display("FAIL ooo_drain got count=%0d we=%b expected 0/00", count, we_reg); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) alloc(2'b00, 5'(8 + i), 3'd0);
        checks++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full got count=%0d ready=%b expected 8/0", count, alloc_ready); end
        checks++; if (alloc_index !== 3'd3) begin errors++; $display("FAIL full_tail got %0d expected 3", alloc_index); end
        cdb(3, 32'd103, 32'd0);
        cdb(4, 32'd104, 32'd0);
        cdb_go();
        checks++; if (we_reg !== 2'b11 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_commit got we=%b ready=%b expected 11/0", we_reg, alloc_ready); end
        tick();
        checks++; if (count !== 4'd6 || alloc_ready !== 1'b1) begin errors++; $display("FAIL full_free got count=%0d ready=%b expected 6/1", count, alloc_ready); end
        cdb(5, 32'd105, 32'd0);
        cdb(6, 32'd106, 32'd0);
        cdb_go();
        tick();
        cdb(7, 32'd107, 32'd0);
        cdb(0, 32'd100, 32'd0);
        cdb_go();
        checks++; if (we_reg !== 2'b11 || rb_index_status_wb !== {3'd0, 3'd7}) begin errors++; $display("FAIL wrap_idx got we=%b idx=%b expected 11/000111", we_reg, rb_index_status_wb); end
        checks++; if (ws_reg !== {5'd13, 5'd12} || wd_reg !== {32'd100, 32'd107}) begin errors++; $display("FAIL wrap_data got ws=%h wd=%h expected %h/%h", ws_reg, wd_reg, {5'd13, 5'd12}, {32'd100, 32'd107}); end
        tick();
        cdb(1, 32'd101, 32'd0);
        cdb(2, 32'd102, 32'd0);
        cdb_go();
        tick();
        checks++; if (count !== 4'd0 || alloc_index !== 3'd3) begin errors++; $display("FAIL wrap_drain got count=%0d tail=%0d expected 0/3", count, alloc_index); end
    endtask

    task automatic test_store_stall();
        alloc(2'b01, 5'd0, 3'd1);
        alloc(2'b00, 5'd9, 3'd2);
        cdb(3, 32'h55, 32'h40);
        cdb(4, 32'h77, 32'h0);
        cdb_go();
        mem_hit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (we_mem !== 1'b1 || ws_mem !== 32'h40 || wd_mem !== 32'h55) begin errors++; $display("FAIL store_hold c%0d got we=%b addr=%h data=%h expected 1/40/55", c, we_mem, ws_mem, wd_mem); end
            checks++; if (we_reg !== 2'b00 || count !== 4'd2) begin errors++; $display("FAIL store_block c%0d got we_reg=%b count=%0d expected 00/2", c, we_reg, count); end
            tick();
        end
        mem_hit = 1'b1;
        tick();
        mem_hit = 1'b0;
        checks++; if (we_mem !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL store_retire got we_mem=%b count=%0d expected 0/1", we_mem, count); end
        checks++; if (we_reg !== 2'b01 || ws_reg[4:0] !== 5'd9 || wd_reg[31:0] !== 32'h77) begin errors++; $display("FAIL store_next got we=%b ws=%0d wd=%h expected 01/9/77", we_reg, ws_reg[4:0], wd_reg[31:0]); end
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL store_drain got %0d expected 0", count); end
    endtask

    task automatic test_taken_branch();
        alloc(2'b10, 5'd0, 3'd0);
        alloc(2'b00, 5'd4, 3'd1);
        alloc(2'b00, 5'd5, 3'd2);
        alloc(2'b01, 5'd0, 3'd5);
        cdb(5, 32'd1, 32'h100);
        cdb_go();
        checks++; if (alloc_ready !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle got ready=%b redir=%b expected 0/0", alloc_ready, redirect_valid); end
        tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++; $display("FAIL redirect got v=%b pc=%h expected 1/100", redirect_valid, redirect_pc); end
        checks++; if (reset_out !== 8'b00100110) begin errors++; $display("FAIL squash got %b expected 00100110", reset_out); end
        checks++; if (count !== 4'd0 || alloc_index !== 3'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL flush_state got count=%0d tail=%0d ready=%b expected 0/0/1", count, alloc_index, alloc_ready); end
        tick();
        checks++; if (redirect_valid !== 1'b0 || reset_out !== 8'h00) begin errors++; $display("FAIL redirect_pulse got v=%b mask=%h expected 0/00", redirect_valid, reset_out); end
    endtask

    task automatic test_not_taken();
        alloc(2'b10, 5'd0, 3'd3);
        alloc(2'b00, 5'd7, 3'd4);
        cdb(0, 32'd0, 32'h200);
        cdb(1, 32'h33, 32'h0);
        cdb_go();
        checks++; if (we_reg !== 2'b00 || alloc_ready !== 1'b1) begin errors++; $display("FAIL nt_alone got we=%b ready=%b expected 00/1", we_reg, alloc_ready); end
        tick();
        checks++; if (we_reg !== 2'b01 || ws_reg[4:0] !== 5'd7 || wd_reg[31:0] !== 32'h33 || count !== 4'd1) begin errors++; $display("FAIL nt_next got we=%b ws=%0d wd=%h count=%0d expected 01/7/33/1", we_reg, ws_reg[4:0], wd_reg[31:0], count); end
        checks++; if (redirect_valid !== 1'b0 || reset_out !== 8'h00) begin errors++; $display("FAIL nt_redirect got v=%b mask=%h expected 0/00", redirect_valid, reset_out); end
        tick();
        checks++; if (count !== 4'd0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL nt_drain got count=%0d v=%b expected 0/0", count, redirect_valid); end
    endtask

    task automatic test_reset_store();
        alloc(2'b01, 5'd0, 3'd0);
        cdb(2, 32'hAA, 32'h80);
        cdb_go();
        checks++; if (we_mem !== 1'b1 || ws_mem !== 32'h80) begin errors++; $display("FAIL rst_store_pending got we=%b addr=%h expected 1/80", we_mem, ws_mem); end
        reset = 1'b0;
        tick();
        checks++; if (we_mem !== 1'b0 || count !== 4'd0 || reset_out !== 8'hFF) begin errors++; $display("FAIL rst_store got we=%b count=%0d mask=%h expected 0/0/ff", we_mem, count, reset_out); end
        reset = 1'b1;
        tick();
        checks++; if (reset_out !== 8'h00 || count !== 4'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_release got mask=%h count=%0d ready=%b expected 00/0/1", reset_out, count, alloc_ready); end
    endtask

    initial begin
        reset       = 1'b0;
        alloc_valid = 1'b0;
        alloc_kind  = 2'b00;
        alloc_rdest = '0;
        alloc_fu    = '0;
        cdb_valid   = '0;
        cdb_data    = '0;
        cdb_addr    = '0;
        mem_hit     = 1'b0;
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_store_stall();
        test_taken_branch();
        test_not_taken();
        test_reset_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
